// File: rtl/ann_phase_sequencer_if.sv
// ----------------------------------------------------------------------------
// ann_phase_sequencer_if
//   Wishbone slave bus bundle for the ANN phase sequencer register window.
//   Signal names keep the Wishbone-slave "_i"/"_o" suffixes as seen from the
//   slave, so the sequencer body reads the same as the flat-port version.
//
//   wbs_cyc_i, wbs_stb_i, wbs_we_i : bus cycle, strobe, write enable
//   wbs_sel_i [3:0]                : byte enables
//   wbs_adr_i [31:0]               : byte address
//   wbs_dat_i [31:0]               : write data
//   wbs_ack_o                      : transfer acknowledge (from slave)
//   wbs_dat_o [31:0]               : read data (from slave)
// ----------------------------------------------------------------------------
interface ann_phase_sequencer_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ann_phase_sequencer.sv
// ----------------------------------------------------------------------------
// ann_phase_sequencer
//   Wishbone-programmable controller that walks the ANN datapath through its
//   reference-load, tree-build and per-query search phases. Firmware programs
//   NUM_Q / TIMEOUT, writes start, then polls STATUS or waits for irq_o.
//
//   Registers (adr[3:2]):
//     0x0 CTRL    W  bit0 start, bit1 abort, bit2 skip_build, bit3 clear_flags
//     0x4 NUM_Q   RW [QW-1:0]
//     0x8 TIMEOUT RW [TW-1:0], 0 disables the watchdog
//     0xC STATUS  R  [2:0] state, 3 busy, 4 done, 5 error, [16+:QW] qry_idx
//
//   Ports:
//     clock, resetb   : clock, asynchronous active-low reset
//     wb (slave)      : Wishbone register window at BASE_ADDR
//     phase_o         : 0 LOAD, 1 BUILD, 2 SEARCH, 3 idle
//     phase_start_o   : one-cycle start for LOAD / BUILD
//     phase_done_i    : one-cycle completion of LOAD / BUILD
//     qry_start_o     : one-cycle start for one search
//     qry_idx_o       : index of the current query
//     qry_done_i      : one-cycle completion of a search
//     irq_o           : level interrupt while done or error is set
// ----------------------------------------------------------------------------
module ann_phase_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned QW        = 10,
    parameter int unsigned TW        = 20
) (
    input  logic                        clock,
    input  logic                        resetb,
    ann_phase_sequencer_if.slave        wb,
    output logic [1:0]                  phase_o,
    output logic                        phase_start_o,
    input  logic                        phase_done_i,
    output logic                        qry_start_o,
    output logic [QW-1:0]               qry_idx_o,
    input  logic                        qry_done_i,
    output logic                        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BUILD  = 3'd2,
        S_SEARCH = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [QW-1:0] num_reg_q, num_reg_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [QW-1:0] num_lat_q, num_lat_d;
    logic          skip_lat_q, skip_lat_d;
    logic [QW-1:0] qry_idx_q, qry_idx_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          done_flag_q, done_flag_d;
    logic          err_flag_q, err_flag_d;
    logic          phase_start_q, phase_start_d;
    logic          qry_start_q, qry_start_d;
    logic [1:0]    phase_q, phase_d;
    logic          irq_q, irq_d;
    logic          ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Bus decode. The ~ack_q term keeps a held strobe from being acked
    // (and acted on) twice in a row.
    // ------------------------------------------------------------------
    logic        hit, wr;
    logic [1:0]  reg_sel;
    logic [31:0] wmask;
    logic        ctrl_wr, start_cmd, abort_cmd, skip_cmd, clear_cmd;
    logic        unused_bits;

    always_comb begin
        hit       = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q &
                    (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        wr        = hit & wb.wbs_we_i;
        reg_sel   = wb.wbs_adr_i[3:2];
        wmask     = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                     {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
        ctrl_wr   = wr & (reg_sel == 2'd0) & wb.wbs_sel_i[0];
        start_cmd = ctrl_wr & wb.wbs_dat_i[0];
        abort_cmd = ctrl_wr & wb.wbs_dat_i[1];
        skip_cmd  = ctrl_wr & wb.wbs_dat_i[2];
        clear_cmd = ctrl_wr & wb.wbs_dat_i[3];
    end

    assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:TW], wmask[31:TW]};

    // Programmable registers with byte enables
    always_comb begin
        num_reg_d = num_reg_q;
        timeout_d = timeout_q;
        if (wr && reg_sel == 2'd1) begin
            num_reg_d = (num_reg_q & ~wmask[QW-1:0]) |
                        (wb.wbs_dat_i[QW-1:0] & wmask[QW-1:0]);
        end
        if (wr && reg_sel == 2'd2) begin
            timeout_d = (timeout_q & ~wmask[TW-1:0]) |
                        (wb.wbs_dat_i[TW-1:0] & wmask[TW-1:0]);
        end
    end

    // Read mux, ack and registered read data
    logic        busy;
    logic [31:0] rd_val;

    always_comb begin
        busy   = (state_q == S_LOAD) || (state_q == S_BUILD) || (state_q == S_SEARCH);
        rd_val = '0;
        case (reg_sel)
            2'd1: rd_val[QW-1:0] = num_reg_q;
            2'd2: rd_val[TW-1:0] = timeout_q;
            2'd3: begin
                rd_val[2:0]     = state_q;
                rd_val[3]       = busy;
                rd_val[4]       = done_flag_q;
                rd_val[5]       = err_flag_q;
                rd_val[16 +: QW] = qry_idx_q;
            end
            default: rd_val = '0;
        endcase
        ack_d   = hit;
        rdata_d = (hit && !wb.wbs_we_i) ? rd_val : '0;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM. Every start pulse clears the watchdog; while waiting
    // it counts up and trips when the incremented count equals TIMEOUT,
    // so TIMEOUT=N lands in ERROR exactly N cycles after the pulse.
    // ------------------------------------------------------------------
    logic [TW-1:0] wdog_inc;
    logic          wdog_hit;
    logic          go_search;

    always_comb begin
        state_d       = state_q;
        num_lat_d     = num_lat_q;
        skip_lat_d    = skip_lat_q;
        qry_idx_d     = qry_idx_q;
        wdog_d        = wdog_q;
        done_flag_d   = done_flag_q;
        err_flag_d    = err_flag_q;
        phase_start_d = 1'b0;
        qry_start_d   = 1'b0;
        go_search     = 1'b0;
        wdog_inc      = wdog_q + TW'(1);
        wdog_hit      = (timeout_q != '0) && (wdog_inc == timeout_q);

        if (clear_cmd) begin
            done_flag_d = 1'b0;
            err_flag_d  = 1'b0;
        end

        if (abort_cmd) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (state_q == S_DONE) state_d = S_IDLE;
                    if (start_cmd) begin
                        state_d       = S_LOAD;
                        num_lat_d     = num_reg_q;
                        skip_lat_d    = skip_cmd;
                        done_flag_d   = 1'b0;
                        err_flag_d    = 1'b0;
                        phase_start_d = 1'b1;
                        wdog_d        = '0;
                    end
                end
                S_LOAD: begin
                    if (phase_done_i) begin
                        if (skip_lat_q) begin
                            go_search = 1'b1;
                        end else begin
                            state_d       = S_BUILD;
                            phase_start_d = 1'b1;
                            wdog_d        = '0;
                        end
                    end else if (wdog_hit) begin
                        state_d    = S_ERROR;
                        err_flag_d = 1'b1;
                    end else begin
                        wdog_d = wdog_inc;
                    end
                end
                S_BUILD: begin
                    if (phase_done_i) begin
                        go_search = 1'b1;
                    end else if (wdog_hit) begin
                        state_d    = S_ERROR;
                        err_flag_d = 1'b1;
                    end else begin
                        wdog_d = wdog_inc;
                    end
                end
                S_SEARCH: begin
                    if (num_lat_q == '0) begin
                        state_d     = S_DONE;
                        done_flag_d = 1'b1;
                    end else if (qry_done_i) begin
                        if (qry_idx_q == num_lat_q - QW'(1)) begin
                            state_d     = S_DONE;
                            done_flag_d = 1'b1;
                        end else begin
                            qry_idx_d   = qry_idx_q + QW'(1);
                            qry_start_d = 1'b1;
                            wdog_d      = '0;
                        end
                    end else if (wdog_hit) begin
                        state_d    = S_ERROR;
                        err_flag_d = 1'b1;
                    end else begin
                        wdog_d = wdog_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // SEARCH entry: restart the index; an empty query set leaves
        // through SEARCH one cycle later with no search pulse.
        if (go_search) begin
            state_d   = S_SEARCH;
            qry_idx_d = '0;
            if (num_lat_q != '0) begin
                qry_start_d = 1'b1;
                wdog_d      = '0;
            end
        end

        case (state_d)
            S_LOAD:   phase_d = 2'd0;
            S_BUILD:  phase_d = 2'd1;
            S_SEARCH: phase_d = 2'd2;
            default:  phase_d = 2'd3;
        endcase
        irq_d = done_flag_d | err_flag_d;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q       <= S_IDLE;
            num_reg_q     <= '0;
            timeout_q     <= '0;
            num_lat_q     <= '0;
            skip_lat_q    <= 1'b0;
            qry_idx_q     <= '0;
            wdog_q        <= '0;
            done_flag_q   <= 1'b0;
            err_flag_q    <= 1'b0;
            phase_start_q <= 1'b0;
            qry_start_q   <= 1'b0;
            phase_q       <= 2'd3;
            irq_q         <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            num_reg_q     <= num_reg_d;
            timeout_q     <= timeout_d;
            num_lat_q     <= num_lat_d;
            skip_lat_q    <= skip_lat_d;
            qry_idx_q     <= qry_idx_d;
            wdog_q        <= wdog_d;
            done_flag_q   <= done_flag_d;
            err_flag_q    <= err_flag_d;
            phase_start_q <= phase_start_d;
            qry_start_q   <= qry_start_d;
            phase_q       <= phase_d;
            irq_q         <= irq_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
        end
    end

    assign wb.wbs_ack_o  = ack_q;
    assign wb.wbs_dat_o  = rdata_q;
    assign phase_o       = phase_q;
    assign phase_start_o = phase_start_q;
    assign qry_start_o   = qry_start_q;
    assign qry_idx_o     = qry_idx_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_ann_phase_sequencer.sv
module tb_ann_phase_sequencer;
    localparam int QW = 10;
    localparam int TW = 20;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_NUMQ = BASE + 32'h4;
    localparam logic [31:0] A_TO   = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic          clock = 1'b0;
    logic          resetb = 1'b1;
    logic [1:0]    phase;
    logic          phase_start;
    logic          phase_done = 1'b0;
    logic          qry_start;
    logic [QW-1:0] qry_idx;
    logic          qry_done = 1'b0;
    logic          irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    ann_phase_sequencer_if wb();

    ann_phase_sequencer #(.BASE_ADDR(BASE), .QW(QW), .TW(TW)) dut (
        .clock         (clock),
        .resetb        (resetb),
        .wb            (wb.slave),
        .phase_o       (phase),
        .phase_start_o (phase_start),
        .phase_done_i  (phase_done),
        .qry_start_o   (qry_start),
        .qry_idx_o     (qry_idx),
        .qry_done_i    (qry_done),
        .irq_o         (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ev(input logic is_qry, input logic [1:0] ph, input logic [QW-1:0] idx);
        return 32'({is_qry, ph, idx});
    endfunction

    // Scoreboard monitor: every start pulse pops one expected event
    always @(negedge clock) begin
        if (resetb && (phase_start || qry_start)) begin
            if (exp_q.size() == 0)
                check("unexpected_pulse", mk_ev(qry_start, phase, qry_start ? qry_idx : '0), 32'hFFFF_FFFF);
            else
                check("pulse", mk_ev(qry_start, phase, qry_start ? qry_idx : '0), exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int acks, output logic [31:0] rdat);
        acks = 0;
        rdat = '0;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb.wbs_ack_o) begin
                acks++;
                rdat = wb.wbs_dat_o;
                break;
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    endtask

    task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int a;
        logic [31:0] d;
        wb_xfer(1'b1, adr, dat, sel, a, d);
        check({tag, "_ack"}, 32'(a), 32'd1);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        int a;
        logic [31:0] d;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, a, d);
        check({tag, "_ack"}, 32'(a), 32'd1);
        check(tag, d, exp);
    endtask

    task automatic pulse_phase_done();
        phase_done = 1'b1;
        tick();
        phase_done = 1'b0;
    endtask

    task automatic pulse_qry_done();
        qry_done = 1'b1;
        tick();
        qry_done = 1'b0;
    endtask

    initial begin
        int a;
        logic [31:0] d;
        logic [3:0] ack_pat;

        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = '0;   wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;

        // Reset state
        #1 resetb = 1'b0;
        #2;
        check("rst_outputs", {26'b0, phase, phase_start, qry_start, irq, wb.wbs_ack_o},
              {26'b0, 2'd3, 4'b0000});
        check("rst_idx_dat", {qry_idx, wb.wbs_dat_o[21:0]}, 32'h0);
        tick(); tick();
        resetb = 1'b1;
        tick();
        wb_read("rst_status", A_STAT, 32'h0);

        // Full run: NUM_Q=3, TIMEOUT=0
        wb_write("w_numq", A_NUMQ, 32'd3, 4'hF);
        wb_write("w_to", A_TO, 32'd0, 4'hF);
        wb_read("r_numq", A_NUMQ, 32'd3);
        exp_q.push_back(mk_ev(1'b0, 2'd0, '0));
        wb_write("w_start", A_CTRL, 32'h1, 4'hF);
        check("start_latency", {29'b0, phase_start, phase}, {29'b0, 1'b1, 2'd0});
        repeat (5) tick();
        exp_q.push_back(mk_ev(1'b0, 2'd1, '0));
        pulse_phase_done();
        check("build_latency", {29'b0, phase_start, phase}, {29'b0, 1'b1, 2'd1});
        repeat (5) tick();
        exp_q.push_back(mk_ev(1'b1, 2'd2, 10'd0));
        pulse_phase_done();
        check("search_entry", {19'b0, qry_start, phase, qry_idx}, {19'b0, 1'b1, 2'd2, 10'd0});
        for (int i = 0; i < 3; i++) begin
            repeat (5) tick();
            if (i < 2) exp_q.push_back(mk_ev(1'b1, 2'd2, QW'(i + 1)));
            pulse_qry_done();
            if (i < 2)
                check("next_qry", {21'b0, qry_start, qry_idx}, {21'b0, 1'b1, 10'(i + 1)});
            else
                check("done_entry", {29'b0, irq, phase}, {29'b0, 1'b1, 2'd3});
        end
        tick();
        wb_read("full_status", A_STAT, 32'h0002_0010);
        check("full_irq", {31'b0, irq}, 32'd1);
        check("full_pending", 32'(exp_q.size()), 32'd0);
        wb_write("w_clear", A_CTRL, 32'h8, 4'hF);
        check("clear_irq", {31'b0, irq}, 32'd0);

        // skip_build with NUM_Q=0
        wb_write("w_numq0", A_NUMQ, 32'd0, 4'hF);
        exp_q.push_back(mk_ev(1'b0, 2'd0, '0));
        wb_write("w_start_skip", A_CTRL, 32'h5, 4'hF);
        repeat (5) tick();
        pulse_phase_done();
        check("skip_search", {29'b0, irq, phase}, {29'b0, 1'b0, 2'd2});
        tick();
        check("skip_done", {29'b0, irq, phase}, {29'b0, 1'b1, 2'd3});
        tick();
        wb_read("skip_status", A_STAT, 32'h0000_0010);
        check("skip_pending", 32'(exp_q.size()), 32'd0);

        // Watchdog: TIMEOUT=8, no done
        wb_write("w_to8", A_TO, 32'd8, 4'hF);
        exp_q.push_back(mk_ev(1'b0, 2'd0, '0));
        wb_write("w_start_wd", A_CTRL, 32'h1, 4'hF);
        check("wd_irq_clr", {31'b0, irq}, 32'd0);
        repeat (7) tick();
        check("wd_before", {29'b0, irq, phase}, {29'b0, 1'b0, 2'd0});
        tick();
        check("wd_trip", {29'b0, irq, phase}, {29'b0, 1'b1, 2'd3});
        wb_read("wd_status", A_STAT, 32'h0000_0025);
        exp_q.push_back(mk_ev(1'b0, 2'd0, '0));
        wb_write("w_restart", A_CTRL, 32'h1, 4'hF);
        check("wd_restart", {28'b0, irq, phase_start, phase}, {28'b0, 1'b0, 1'b1, 2'd0});
        wb_write("w_abort_wd", A_CTRL, 32'h2, 4'hF);
        check("wd_abort", {30'b0, phase}, 32'd3);
        wb_write("w_to0", A_TO, 32'd0, 4'hF);

        // Abort mid-SEARCH at idx 1 of NUM_Q=4
        wb_write("w_numq4", A_NUMQ, 32'd4, 4'hF);
        exp_q.push_back(mk_ev(1'b0, 2'd0, '0));
        wb_write("w_start_ab", A_CTRL, 32'h5, 4'hF);
        repeat (5) tick();
        exp_q.push_back(mk_ev(1'b1, 2'd2, 10'd0));
        pulse_phase_done();
        repeat (5) tick();
        exp_q.push_back(mk_ev(1'b1, 2'd2, 10'd1));
        pulse_qry_done();
        check("ab_idx1", {21'b0, qry_start, qry_idx}, {21'b0, 1'b1, 10'd1});
        tick();
        wb_write("w_abort", A_CTRL, 32'h2, 4'hF);
        check("ab_idle", {29'b0, qry_start, phase}, {29'b0, 1'b0, 2'd3});
        repeat (3) tick();
        pulse_qry_done();
        repeat (5) tick();
        check("ab_late", {29'b0, irq, phase}, {29'b0, 1'b0, 2'd3});
        wb_read("ab_status", A_STAT, 32'h0001_0000);
        check("ab_pending", 32'(exp_q.size()), 32'd0);

        // Bus behaviour
        wb_write("w_numq1", A_NUMQ, 32'd1, 4'hF);
        exp_q.push_back(mk_ev(1'b0, 2'd0, '0));
        wb_write("w_start_b", A_CTRL, 32'h1, 4'hF);
        tick();
        wb_write("w_start_busy", A_CTRL, 32'h1, 4'hF);
        check("busy_ignored", {29'b0, phase_start, phase}, {29'b0, 1'b0, 2'd0});
        wb_read("busy_status", A_STAT, 32'h0001_0009);
        wb_write("w_abort_b", A_CTRL, 32'h2, 4'hF);
        check("b_abort", {30'b0, phase}, 32'd3);
        wb_write("w_start_abort", A_CTRL, 32'h3, 4'hF);
        check("abort_wins", {29'b0, phase_start, phase}, {29'b0, 1'b0, 2'd3});
        wb_write("w_start_nosel0", A_CTRL, 32'h1, 4'b1110);
        check("sel0_gate", {29'b0, phase_start, phase}, {29'b0, 1'b0, 2'd3});
        wb_read("ctrl_read", A_CTRL, 32'h0);
        wb_write("w_to_full", A_TO, 32'h0001_2345, 4'hF);
        wb_write("w_to_byte1", A_TO, 32'hAAAA_AAAA, 4'b0010);
        wb_read("to_bytemask", A_TO, 32'h0001_AA45);
        wb_read("b2b_numq", A_NUMQ, 32'd1);
        wb_read("b2b_to", A_TO, 32'h0001_AA45);
        wb_write("w_to_zero", A_TO, 32'd0, 4'hF);
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, a, d);
        check("oor_noack", 32'(a), 32'd0);
        // Held strobe: acks must alternate, never two in a row
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = A_STAT; wb.wbs_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack_pat[i] = wb.wbs_ack_o;
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        check("ack_alternate", {28'b0, ack_pat}, 32'h5);
        check("bus_pending", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during BUILD
        tick();
        exp_q.push_back(mk_ev(1'b0, 2'd0, '0));
        wb_write("w_start_r", A_CTRL, 32'h1, 4'hF);
        repeat (5) tick();
        pulse_phase_done();
        check("r_build", {29'b0, phase_start, phase}, {29'b0, 1'b1, 2'd1});
        #1 resetb = 1'b0;
        #1;
        check("r_async", {26'b0, phase, phase_start, qry_start, irq, wb.wbs_ack_o},
              {26'b0, 2'd3, 4'b0000});
        check("r_idx", {22'b0, qry_idx}, 32'h0);
        tick(); tick();
        resetb = 1'b1;
        tick();
        wb_read("r_status", A_STAT, 32'h0);
        wb_read("r_numq", A_NUMQ, 32'h0);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
